// File: rtl/rosetta_pkg.sv
// Shared types and constants for the rosetta run controller: FSM state
// encoding, CSR address map and CTRL/STATUS bit positions.
package rosetta_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } run_state_e;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_BOUND  = 3'd2;
    localparam logic [2:0] ADDR_CYCLES = 3'd3;
    localparam logic [2:0] ADDR_RUNS   = 3'd4;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_ABORT_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;
    localparam int STATUS_ABORT_BIT = 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rosetta_run_ctrl_if.sv
// CSR bus and memory host-port handshake of the rosetta run controller.
// master = CPU/host side, slave = run controller.
interface rosetta_run_ctrl_if #(
    parameter int NUM_MEM = 6
) ();
    logic               csr_cs;
    logic               csr_r;
    logic               csr_w;
    logic [2:0]         csr_addr;
    logic [31:0]        csr_wdata;
    logic [31:0]        csr_rdata;
    logic               csr_rvalid;
    logic [NUM_MEM-1:0] host_req;
    logic [NUM_MEM-1:0] host_waitreq;
    logic               host_sel;

    modport master (
        output csr_cs, csr_r, csr_w, csr_addr, csr_wdata, host_req,
        input  csr_rdata, csr_rvalid, host_waitreq, host_sel
    );

    modport slave (
        input  csr_cs, csr_r, csr_w, csr_addr, csr_wdata, host_req,
        output csr_rdata, csr_rvalid, host_waitreq, host_sel
    );
endinterface

// File: rtl/rosetta_run_fsm.sv
// Run sequencing FSM (IDLE/ARM/RUN/DRAIN) with the drain cycle counter.
// Emits single-cycle transition events consumed by the CSR/status logic.
module rosetta_run_fsm
    import rosetta_pkg::*;
#(
    parameter int DRAIN_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_go,
    input  logic       abort_go,
    input  logic       core_done,
    output run_state_e cur_state,
    output logic       core_rst,
    output logic       run_state,
    output logic       host_sel,
    output logic       arm_evt,
    output logic       done_evt,
    output logic       abort_evt,
    output logic       finish_evt
);

    run_state_e state_reg, state_next;
    logic [3:0] drain_cnt_reg, drain_cnt_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            drain_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            ST_IDLE:  if (start_go) state_next = ST_ARM;
            ST_ARM:   state_next = ST_RUN;
            ST_RUN: begin
                if (core_done || abort_go) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = 4'(DRAIN_CYC - 1);
                end
            end
            ST_DRAIN: begin
                // Counter holds the number of DRAIN cycles still to follow.
                if (drain_cnt_reg == 4'd0) state_next = ST_IDLE;
                else                       drain_cnt_next = drain_cnt_reg - 4'd1;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_state  = state_reg;
        core_rst   = (state_reg != ST_RUN);
        run_state  = (state_reg != ST_IDLE);
        host_sel   = (state_reg == ST_IDLE);
        arm_evt    = (state_reg == ST_IDLE) && start_go;
        done_evt   = (state_reg == ST_RUN) && core_done;
        abort_evt  = (state_reg == ST_RUN) && abort_go && !core_done;
        finish_evt = (state_reg == ST_DRAIN) && (drain_cnt_reg == 4'd0);
    end

endmodule

// File: rtl/rosetta_run_ctrl.sv
// Run controller top: CSR decode, status/irq flags, run counter and host
// memory gating. Optional cycle counter at CSR 3 built with ROSETTA_PERF_CNT_EN.
module rosetta_run_ctrl
    import rosetta_pkg::*;
#(
    parameter int                 NUM_MEM   = 6,
    parameter int                 BOUND_W   = 7,
    parameter logic [BOUND_W-1:0] BOUND_RST = '1,
    parameter int                 DRAIN_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    rosetta_run_ctrl_if.slave  bus,
    output logic               core_rst,
    input  logic               core_done,
    output logic               state,
    output logic [BOUND_W-1:0] bound_info,
    output logic               irq
);

    logic       wr_acc, rd_acc, ctrl_wr, status_wr, bound_wr;
    logic       start_go, abort_go;
    logic       arm_evt, done_evt, abort_evt, finish_evt;
    logic       host_sel_int;
    run_state_e fsm_state;

    logic               irq_en_reg, irq_en_next;
    logic               done_reg, done_next;
    logic               aborted_reg, aborted_next;
    logic               run_done_reg, run_done_next;
    logic               irq_reg;
    logic [15:0]        runs_reg;
    logic [BOUND_W-1:0] bound_reg;
    logic               rvalid_reg;
    logic [31:0]        rdata_reg, rd_mux;
    logic [31:0]        cyc_val;
    logic               unused_wdata;

    assign wr_acc    = bus.csr_cs && bus.csr_w && !bus.csr_r;
    assign rd_acc    = bus.csr_cs && bus.csr_r && !bus.csr_w;
    assign ctrl_wr   = wr_acc && (bus.csr_addr == ADDR_CTRL);
    assign status_wr = wr_acc && (bus.csr_addr == ADDR_STATUS);
    assign bound_wr  = wr_acc && (bus.csr_addr == ADDR_BOUND);
    // Abort in the same write suppresses the start.
    assign start_go  = ctrl_wr && bus.csr_wdata[CTRL_START_BIT] && !bus.csr_wdata[CTRL_ABORT_BIT];
    assign abort_go  = ctrl_wr && bus.csr_wdata[CTRL_ABORT_BIT];
    assign unused_wdata = ^bus.csr_wdata;

    rosetta_run_fsm #(.DRAIN_CYC(DRAIN_CYC)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .start_go   (start_go),
        .abort_go   (abort_go),
        .core_done  (core_done),
        .cur_state  (fsm_state),
        .core_rst   (core_rst),
        .run_state  (state),
        .host_sel   (host_sel_int),
        .arm_evt    (arm_evt),
        .done_evt   (done_evt),
        .abort_evt  (abort_evt),
        .finish_evt (finish_evt)
    );

    assign bus.host_sel = host_sel_int;

    for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_wait
        assign bus.host_waitreq[gi] = bus.host_req[gi] && !host_sel_int;
    end

    always_comb begin
        irq_en_next   = irq_en_reg;
        done_next     = done_reg;
        aborted_next  = aborted_reg;
        run_done_next = run_done_reg;
        if (ctrl_wr) irq_en_next = bus.csr_wdata[CTRL_IRQ_EN_BIT];
        if (status_wr) begin
            if (bus.csr_wdata[STATUS_DONE_BIT])  done_next    = 1'b0;
            if (bus.csr_wdata[STATUS_ABORT_BIT]) aborted_next = 1'b0;
        end
        if (arm_evt) begin
            done_next     = 1'b0;
            aborted_next  = 1'b0;
            run_done_next = 1'b0;
        end
        // run_done survives a STATUS clear so RUNS still counts this run.
        if (done_evt) begin
            done_next     = 1'b1;
            run_done_next = 1'b1;
        end
        if (abort_evt) aborted_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_en_reg   <= 1'b0;
            done_reg     <= 1'b0;
            aborted_reg  <= 1'b0;
            run_done_reg <= 1'b0;
            irq_reg      <= 1'b0;
            runs_reg     <= 16'd0;
            bound_reg    <= BOUND_RST;
        end else begin
            irq_en_reg   <= irq_en_next;
            done_reg     <= done_next;
            aborted_reg  <= aborted_next;
            run_done_reg <= run_done_next;
            irq_reg      <= irq_en_next && (done_next || aborted_next);
            if (finish_evt && run_done_reg) runs_reg <= sat_inc16(runs_reg);
            if (bound_wr) bound_reg <= bus.csr_wdata[BOUND_W-1:0];
        end
    end

`ifdef ROSETTA_PERF_CNT_EN
    logic [31:0] cyc_reg;

    always_ff @(posedge clk) begin
        if (!rst)                                         cyc_reg <= 32'd0;
        else if (arm_evt)                                 cyc_reg <= 32'd0;
        else if (fsm_state != ST_IDLE && cyc_reg != '1)   cyc_reg <= cyc_reg + 32'd1;
    end

    assign cyc_val = cyc_reg;
`else
    assign cyc_val = 32'd0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (bus.csr_addr)
            ADDR_CTRL:   rd_mux[CTRL_IRQ_EN_BIT] = irq_en_reg;
            ADDR_STATUS: begin
                rd_mux[STATUS_BUSY_BIT]  = (fsm_state != ST_IDLE);
                rd_mux[STATUS_DONE_BIT]  = done_reg;
                rd_mux[STATUS_ABORT_BIT] = aborted_reg;
            end
            ADDR_BOUND:  rd_mux = 32'(bound_reg);
            ADDR_CYCLES: rd_mux = cyc_val;
            ADDR_RUNS:   rd_mux = 32'(runs_reg);
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= 32'd0;
        end else begin
            rvalid_reg <= rd_acc;
            if (rd_acc) rdata_reg <= rd_mux;
        end
    end

    assign bus.csr_rvalid = rvalid_reg;
    assign bus.csr_rdata  = rdata_reg;
    assign bound_info     = bound_reg;
    assign irq            = irq_reg;

endmodule

// File: tb/tb_rosetta_run_ctrl.sv
// Self-checking bench for rosetta_run_ctrl: CSR vector table, hand-written
// corner sequences and randomized runs checked against a run-level model.
module tb_rosetta_run_ctrl;

    localparam int NM = 6;
    localparam int BW = 7;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          core_rst, core_done, state, irq;
    logic [BW-1:0] bound_info;

    int checks = 0;
    int errors = 0;
    int runs_model = 0;

    rosetta_run_ctrl_if #(.NUM_MEM(NM)) bus ();

    rosetta_run_ctrl #(
        .NUM_MEM   (NM),
        .BOUND_W   (BW),
        .BOUND_RST ('1),
        .DRAIN_CYC (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .core_rst   (core_rst),
        .core_done  (core_done),
        .state      (state),
        .bound_info (bound_info),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } csr_vec_t;

    csr_vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.csr_cs = 1'b0; bus.csr_r = 1'b0; bus.csr_w = 1'b0;
        core_done  = 1'b0;
    endtask

    task automatic drive_write(input logic [2:0] a, input logic [31:0] d);
        bus.csr_cs = 1'b1; bus.csr_w = 1'b1; bus.csr_r = 1'b0;
        bus.csr_addr = a; bus.csr_wdata = d;
    endtask

    // Called at a negedge; returns at the negedge after the write is sampled.
    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        drive_write(a, d);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        bus.csr_cs = 1'b1; bus.csr_r = 1'b1; bus.csr_w = 1'b0; bus.csr_addr = a;
        @(negedge clk);
        idle_bus();
        chk("rvalid", 32'(bus.csr_rvalid), 32'd1);
        d = bus.csr_rdata;
    endtask

    task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        csr_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (state == 1'b0) break;
            @(negedge clk);
        end
        chk("wait_idle", 32'(state), 32'd0);
    endtask

    // One complete run of L RUN cycles; expectations derive from the phase
    // position within the run (ARM, L x RUN, D x DRAIN, then IDLE).
    task automatic do_run(input int L, input bit use_done, input bit use_abort,
                          input bit ien, input bit extra_start, input bit drain_done);
        bit          end_done  = use_done;
        bit          end_abort = use_abort && !use_done;
        int          total     = 1 + L + D;
        logic [NM-1:0] exp_wait;
        logic [31:0] exp_cyc;
        csr_write(3'd0, 32'h1 | (32'(ien) << 2));
        for (int i = 0; i <= total; i++) begin
            bus.host_req = NM'($urandom);
            #1;
            exp_wait = (i < total) ? bus.host_req : '0;
            chk("run_state",   32'(state),            32'(i < total));
            chk("run_core_rst", 32'(core_rst),        32'(!(i >= 1 && i <= L)));
            chk("run_host_sel", 32'(bus.host_sel),    32'(i >= total));
            chk("run_waitreq", 32'(bus.host_waitreq), 32'(exp_wait));
            chk("run_irq",     32'(irq),              32'(ien && (i >= L + 1)));
            if (i == 0 && extra_start) drive_write(3'd0, 32'h1 | (32'(ien) << 2));
            if (i == L) begin
                if (use_done)  core_done = 1'b1;
                if (use_abort) drive_write(3'd0, 32'h2 | (32'(ien) << 2));
            end
            if (drain_done && i == L + 2) core_done = 1'b1;
            @(negedge clk);
            idle_bus();
        end
        if (end_done && runs_model < 65535) runs_model++;
`ifdef ROSETTA_PERF_CNT_EN
        exp_cyc = 32'(total);
`else
        exp_cyc = 32'd0;
`endif
        read_chk("post_status", 3'd1, {29'd0, end_abort, end_done, 1'b0});
        read_chk("post_runs",   3'd4, 32'(runs_model));
        read_chk("post_cycles", 3'd3, exp_cyc);
        if (ien) begin
            csr_write(3'd1, 32'h6);
            chk("irq_clear", 32'(irq), 32'd0);
            read_chk("status_clr", 3'd1, 32'd0);
        end
        $display("run L=%0d done=%0b abort=%0b irq_en=%0b -> runs=%0d", L, use_done, use_abort, ien, runs_model);
    endtask

    initial begin
        logic [31:0] d;

        vecs[0]  = '{0, 3'd2, 32'h0, 32'h7F};
        vecs[1]  = '{0, 3'd1, 32'h0, 32'h0};
        vecs[2]  = '{0, 3'd0, 32'h0, 32'h0};
        vecs[3]  = '{0, 3'd4, 32'h0, 32'h0};
        vecs[4]  = '{0, 3'd3, 32'h0, 32'h0};
        vecs[5]  = '{0, 3'd7, 32'h0, 32'h0};
        vecs[6]  = '{1, 3'd2, 32'h55, 32'h0};
        vecs[7]  = '{0, 3'd2, 32'h0, 32'h55};
        vecs[8]  = '{1, 3'd2, 32'hFFFFFFAA, 32'h0};
        vecs[9]  = '{0, 3'd2, 32'h0, 32'h2A};
        vecs[10] = '{1, 3'd0, 32'h4, 32'h0};
        vecs[11] = '{0, 3'd0, 32'h0, 32'h4};
        vecs[12] = '{1, 3'd0, 32'h0, 32'h0};
        vecs[13] = '{0, 3'd0, 32'h0, 32'h0};
        vecs[14] = '{1, 3'd6, 32'hFFFFFFFF, 32'h0};
        vecs[15] = '{0, 3'd6, 32'h0, 32'h0};
        vecs[16] = '{1, 3'd0, 32'h3, 32'h0};
        vecs[17] = '{0, 3'd1, 32'h0, 32'h0};
        vecs[18] = '{1, 3'd1, 32'h6, 32'h0};
        vecs[19] = '{0, 3'd1, 32'h0, 32'h0};
        vecs[20] = '{1, 3'd2, 32'h7F, 32'h0};
        vecs[21] = '{0, 3'd2, 32'h0, 32'h7F};

        idle_bus();
        bus.csr_addr = 3'd0; bus.csr_wdata = 32'd0; bus.host_req = '1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_core_rst", 32'(core_rst),         32'd1);
        chk("rst_state",    32'(state),            32'd0);
        chk("rst_host_sel", 32'(bus.host_sel),     32'd1);
        chk("rst_waitreq",  32'(bus.host_waitreq), 32'd0);
        chk("rst_rvalid",   32'(bus.csr_rvalid),   32'd0);
        chk("rst_rdata",    bus.csr_rdata,         32'd0);
        chk("rst_irq",      32'(irq),              32'd0);
        chk("rst_bound",    32'(bound_info),       32'h7F);
        @(negedge clk);

        foreach (vecs[k]) begin
            if (vecs[k].wr) begin
                csr_write(vecs[k].addr, vecs[k].data);
                chk("vec_no_run", 32'(state), 32'd0);
                $display("vec %0d: write addr %0d data %h", k, vecs[k].addr, vecs[k].data);
            end else begin
                csr_read(vecs[k].addr, d);
                chk("vec_read", d, vecs[k].exp);
                $display("vec %0d: read addr %0d data %h", k, vecs[k].addr, d);
            end
        end

        // rvalid is a one-cycle pulse and rdata holds afterwards.
        read_chk("hold_read", 3'd2, 32'h7F);
        @(negedge clk);
        chk("rvalid_drop", 32'(bus.csr_rvalid), 32'd0);
        chk("rdata_hold",  bus.csr_rdata,       32'h7F);
        // Read and write together: neither happens.
        bus.csr_cs = 1'b1; bus.csr_r = 1'b1; bus.csr_w = 1'b1;
        bus.csr_addr = 3'd2; bus.csr_wdata = 32'h0;
        @(negedge clk);
        idle_bus();
        chk("rw_no_rvalid", 32'(bus.csr_rvalid), 32'd0);
        read_chk("rw_no_write", 3'd2, 32'h7F);
        $display("seq: read/write collision");

        // core_done in IDLE is ignored.
        core_done = 1'b1;
        @(negedge clk);
        idle_bus();
        read_chk("idle_done_status", 3'd1, 32'd0);
        read_chk("idle_done_runs",   3'd4, 32'd0);
        $display("seq: core_done in idle");

        // Abort mid-run, start in RUN ignored, STATUS read during DRAIN.
        csr_write(3'd0, 32'h1);
        @(negedge clk);
        csr_write(3'd0, 32'h1);
        chk("start_in_run_state",    32'(state),    32'd1);
        chk("start_in_run_core_rst", 32'(core_rst), 32'd0);
        csr_write(3'd0, 32'h2);
        read_chk("drain_status", 3'd1, 32'h5);
        wait_idle();
        read_chk("abort_status", 3'd1, 32'h4);
        read_chk("abort_runs",   3'd4, 32'd0);
        $display("seq: abort in run");

        do_run(10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_run(3,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        do_run(5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        do_run(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 12; r++) begin
            int m = $urandom_range(0, 2);
            do_run($urandom_range(1, 12), m != 1, m != 0, 1'($urandom),
                   1'($urandom), 1'($urandom));
        end

        // Reset in the middle of RUN.
        csr_write(3'd2, 32'h11);
        csr_write(3'd0, 32'h5);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        runs_model = 0;
        chk("mrst_state",    32'(state),        32'd0);
        chk("mrst_host_sel", 32'(bus.host_sel), 32'd1);
        chk("mrst_core_rst", 32'(core_rst),     32'd1);
        chk("mrst_irq",      32'(irq),          32'd0);
        read_chk("mrst_status", 3'd1, 32'd0);
        read_chk("mrst_runs",   3'd4, 32'(runs_model));
        read_chk("mrst_bound",  3'd2, 32'h7F);
        read_chk("mrst_ctrl",   3'd0, 32'd0);
        $display("seq: reset mid-run");
        do_run(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rosetta_run_ctrl.md
ROSETTA_RUN_CTRL -- requirements
Module: rosetta_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_MEM, default 6, number of memory host ports gated by this block.
REQ-002 SHALL have parameter BOUND_W, default 7, width of the bound_info field; BOUND_RST, default all-ones, its reset value.
REQ-003 SHALL have parameter DRAIN_CYC, default 4 (range 1..15), cycles memories stay core-owned after run end.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-low (one clock; rst low at a posedge resets).
REQ-005 SHALL have ports: csr_cs in 1, csr_r in 1, csr_w in 1, csr_addr in 3, csr_wdata in 32, csr_rdata out 32, csr_rvalid out 1.
REQ-006 SHALL have ports: core_rst out 1 (core held in reset when high), core_done in 1 (single-cycle pulse), state out 1 (0 idle, 1 work), bound_info out BOUND_W, irq out 1.
REQ-007 SHALL have ports: host_req in NUM_MEM (per-memory host access request), host_waitreq out NUM_MEM, host_sel out 1 (1 = host owns memories).

Function
REQ-008 SHALL accept a CSR write only when csr_cs & csr_w & ~csr_r, a read only when csr_cs & csr_r & ~csr_w; both asserted = no-op.
REQ-009 SHALL return read data on csr_rdata with csr_rvalid high exactly one cycle after the accepted read; otherwise csr_rvalid low, csr_rdata holds.
REQ-010 SHALL map: 0 CTRL (w: bit0 start, bit1 abort, self-clearing; r/w bit2 irq_en); 1 STATUS (r: bit0 busy, bit1 done, bit2 aborted; write 1 to bits1/2 clears them); 2 BOUND (r/w bound_info, low BOUND_W bits); 4 RUNS (r: completed-run count, 16 bits, saturating); unmapped addresses read 0, writes ignored.
REQ-011 SHALL implement states IDLE, ARM, RUN, DRAIN.
REQ-012 IDLE: start write -> ARM; core_rst=1, state=0, host_sel=1.
REQ-013 ARM: lasts exactly one cycle, core_rst=1, state=1, host_sel=0; -> RUN.
REQ-014 RUN: core_rst=0, state=1; core_done -> DRAIN with done set; abort write -> DRAIN with aborted set, done unchanged.
REQ-015 DRAIN: core_rst=1, state=1, host_sel=0 for exactly DRAIN_CYC cycles, then -> IDLE; RUNS increments on the DRAIN->IDLE transition only when done was set by this run.
REQ-016 Start write outside IDLE SHALL be ignored; abort outside RUN SHALL be ignored.
REQ-017 Start and abort in the same IDLE write: abort wins, no run starts.
REQ-018 core_done and abort write in the same RUN cycle: treated as done; aborted not set.
REQ-019 core_done outside RUN SHALL be ignored.
REQ-020 STATUS.busy SHALL equal (state != IDLE); a start clears done and aborted on IDLE->ARM.
REQ-021 host_waitreq[i] SHALL equal host_req[i] & ~host_sel, combinationally.
REQ-022 irq SHALL be registered, high while irq_en & (done | aborted).
REQ-023 BOUND writes SHALL be accepted in any state and take effect the next cycle.

Reset
REQ-024 On rst low: state IDLE, core_rst=1, state=0, host_sel=1, csr_rvalid=0, csr_rdata=0, irq=0, irq_en=0, done=0, aborted=0, RUNS=0, bound_info=BOUND_RST, cycle counter=0.
REQ-025 Reset mid-RUN or mid-DRAIN SHALL return to IDLE in one cycle with no RUNS increment.

Configuration
REQ-026 With ROSETTA_PERF_CNT_EN defined: 32-bit cycle counter at address 3, cleared on IDLE->ARM, incremented each cycle in ARM/RUN/DRAIN, saturating at all-ones, read-only.
REQ-027 Without ROSETTA_PERF_CNT_EN: no counter logic; address 3 reads 0.

Structure
REQ-028 Shared package rosetta_pkg SHALL hold the state enum, CSR address constants, CTRL/STATUS bit indices.
REQ-029 The FSM plus DRAIN counter SHALL be sub-module rosetta_run_fsm; CSR decode, status flags, counters in the top.

Verification
REQ-030 Reset, read addr 2 -> rdata 0x7F one cycle later, rvalid=1; addr 1 -> 0.
REQ-031 Write CTRL=1, core_done 10 cycles later -> state 1 for ARM+RUN+4 DRAIN cycles, STATUS=0x2, RUNS=1, cycles=15 (macro on).
REQ-032 During RUN, host_req=6'b000101 -> host_waitreq=6'b000101; in IDLE -> 0.
REQ-033 Write CTRL=3 in IDLE -> no run; in RUN write CTRL=2 -> STATUS=0x5 during DRAIN, 0x4 in IDLE, RUNS unchanged.
REQ-034 irq_en=1, run to done -> irq=1; write STATUS=0x2 -> irq=0 next cycle.
REQ-035 rst low during RUN -> next cycle IDLE, host_sel=1, STATUS=0, RUNS unchanged=0.
